param_sync_fifo: RTL
====================

Name: param_sync_fifo

Overview:
Parametrised single-clock FIFO. Generalises the team's fixed 8x4 FIFO to any data width and any depth, including non-power-of-two depths. Adds valid/ready handshakes, show-ahead read data, a fill-level output, programmable almost-full and almost-empty flags, and a synchronous flush. Sits between producer and consumer blocks in the same clock domain as the standard elastic buffer.

Parameters:
DATA_W, 8, width of each entry in bits
DEPTH, 4, number of entries; any integer >= 2
AF_THRESH, DEPTH-1, almost_full asserts when level >= AF_THRESH
AE_THRESH, 1, almost_empty asserts when level <= AE_THRESH

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous clear of contents and pointers
wr_valid  in  1  producer has data
wr_ready  out  1  FIFO can accept data; equals !full
wr_data  in  DATA_W  write data
rd_valid  out  1  head entry valid; equals !empty
rd_ready  in  1  consumer takes the head entry
rd_data  out  DATA_W  head entry (show-ahead); all-zero when empty
level  out  $clog2(DEPTH+1)  number of stored entries
full  out  1  level == DEPTH
empty  out  1  level == 0
half_full  out  1  level >= DEPTH/2 (integer division)
almost_full  out  1  level >= AF_THRESH
almost_empty  out  1  level <= AE_THRESH

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset: wr_ptr=0, rd_ptr=0, level=0. Outputs after reset: empty=1, full=0, rd_valid=0, wr_ready=1, rd_data=0, half_full=0, almost_full=0, almost_empty=1.
- Storage array is not reset.
- Push: wr_valid && wr_ready. On the next edge mem[wr_ptr] <= wr_data and wr_ptr advances.
- Pop: rd_valid && rd_ready. On the next edge rd_ptr advances.
- rd_data is combinational from mem[rd_ptr]. It is gated to zero when empty. Z and X are never driven.
- Latency: a word written at edge N is visible on rd_data with rd_valid=1 after edge N. There is no write-to-read bypass.
- Pointers wrap from DEPTH-1 to 0. Wrap is by explicit compare, not natural overflow, so non-power-of-two depths work.
- level update per cycle: push only adds 1; pop only subtracts 1; push and pop together leave it unchanged; neither leaves it unchanged.
- Full: wr_ready=0, so a write attempt is ignored and memory and level are untouched. A pop while full is allowed; wr_ready rises on the following cycle.
- Empty: rd_valid=0, so rd_ready is ignored. A push while empty does not produce same-cycle read data.
- Simultaneous push and pop at 0 < level < DEPTH: both take effect.
- Priority: rst > flush > push/pop.
- flush clears pointers and level on the next edge. A push or pop in the same cycle is discarded.
- Reset or flush mid-stream drops all stored words. All flags are derived from the post-edge level.
- All flags are combinational decodes of registered level. No flag depends on current-cycle inputs.

Optional Feature:
- Macro: PARAM_SYNC_FIFO_ERR_EN.
- When defined, two sticky outputs are added: ovf (1 bit) and udf (1 bit).
  - ovf sets on wr_valid && !wr_ready.
  - udf sets on rd_ready && !rd_valid.
  - Each stays at 1 until rst or flush.
- When not defined, these ports and their logic are absent, and push/pop behaviour is unchanged.

Decomposition:
- Package fifo_pkg holds:
  - function ptr_next(ptr, depth), the wrap-around increment;
  - localparam helpers for LVL_W = $clog2(DEPTH+1) and PTR_W = (DEPTH>1 ? $clog2(DEPTH) : 1).
- Sub-module fifo_wrap_ptr is a PTR_W-bit counter with clear, enable and wrap at DEPTH-1. It is instantiated twice, once for the read pointer and once for the write pointer.

Test Plan:
(All scenarios use DATA_W=8, DEPTH=5, AF_THRESH=4, AE_THRESH=1.)
1. Reset then fill: write 0x11,0x22,0x33,0x44,0x55 back-to-back.
   -> level goes 1..5; half_full from level 2; almost_empty clears at level 2; almost_full at level 4; full and wr_ready=0 after the 5th write.
2. Drain from full: hold rd_ready=1 for 5 cycles.
   -> rd_data is 0x11..0x55 in order; empty=1 after the 5th pop; rd_data=0x00.
3. Wrap-around: 4 rounds of 3 writes (values 0x01..0x0C) followed by 3 reads.
   -> all 12 words read in order; pointers pass index 4 to 0 without a gap.
4. Simultaneous push and pop at level 2 (head 0xA1), writing 0xB2.
   -> level stays 2; rd_data becomes the 2nd entry; 0xB2 is appended at the tail.
5. Overflow: at full, assert wr_valid with 0xEE for 2 cycles.
   -> level stays 5; 0xEE is never read.
   -> With PARAM_SYNC_FIFO_ERR_EN: ovf=1, held until flush.
6. Flush and reset mid-stream:
   -> At level 3, flush with wr_valid=1: next cycle level=0, empty=1, written word dropped.
   -> Repeat with rst=1 and flush=1 together: same result, and all flags return to their reset values.

Source files
------------

// File: rtl/param_sync_fifo_pkg.sv
// Shared helpers for param_sync_fifo: pointer/level width calculation and
// the wrap-around pointer increment that keeps non-power-of-two depths legal.
package fifo_pkg;

    localparam int unsigned MIN_DEPTH = 32'd2;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 32'd1) ? $clog2(depth) : 32'd1;
    endfunction

    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth + 32'd1);
    endfunction

    // Explicit compare against depth-1 rather than relying on binary overflow
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/param_sync_fifo_wrap_ptr.sv
// Wrap-around FIFO pointer: PTR_W-bit counter with clear and enable that
// returns to zero after DEPTH-1.
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Next pointer: clear wins over advance
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (en_i) begin
            ptr_d = PTR_W'(ptr_next(32'(ptr_q), DEPTH));
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with valid/ready handshakes, show-ahead read
// data, level and threshold flags. Define PARAM_SYNC_FIFO_ERR_EN for sticky ovf/udf.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AF_THRESH = DEPTH - 1,
    parameter int unsigned AE_THRESH = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [DATA_W-1:0]         rd_data,
    output logic [lvl_w(DEPTH)-1:0]   level,
    output logic                      full,
    output logic                      empty,
    output logic                      half_full,
    output logic                      almost_full,
    output logic                      almost_empty
`ifdef PARAM_SYNC_FIFO_ERR_EN
    ,
    output logic                      ovf,
    output logic                      udf
`endif
);

    localparam int unsigned LVL_W = lvl_w(DEPTH);
    localparam int unsigned PTR_W = ptr_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_d;
    logic [PTR_W-1:0]  wr_ptr_s;
    logic [PTR_W-1:0]  rd_ptr_s;
    logic              push_s;
    logic              pop_s;

    assign full         = (level_q == LVL_W'(DEPTH));
    assign empty        = (level_q == LVL_W'(0));
    assign half_full    = (level_q >= LVL_W'(DEPTH / 32'd2));
    assign almost_full  = (level_q >= LVL_W'(AF_THRESH));
    assign almost_empty = (level_q <= LVL_W'(AE_THRESH));
    assign level        = level_q;

    assign wr_ready = !full;
    assign rd_valid = !empty;
    assign push_s   = wr_valid && wr_ready;
    assign pop_s    = rd_valid && rd_ready;
    assign rd_data  = empty ? '0 : mem_q[rd_ptr_s];

    fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .en_i  (push_s),
        .ptr_o (wr_ptr_s)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .en_i  (pop_s),
        .ptr_o (rd_ptr_s)
    );

    // Next fill level; flush discards any same-cycle push or pop
    always_comb begin
        level_d = level_q;
        if (flush) begin
            level_d = '0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Level register
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (push_s && !flush && !rst) begin
            mem_q[wr_ptr_s] <= wr_data;
        end
    end

`ifdef PARAM_SYNC_FIFO_ERR_EN
    logic ovf_q;
    logic udf_q;

    // Sticky overflow/underflow, cleared only by reset or flush
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (wr_valid & ~wr_ready);
            udf_q <= udf_q | (rd_ready & ~rd_valid);
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`endif

endmodule
